lyap_frame_engine: RTL and testbench

LYAP_FRAME_ENGINE -- requirements
Module: lyap_frame_engine

---
 rtl/lyap_frame_engine_pkg.sv | 17 +
 rtl/lyap_frame_engine_colormap.sv | 50 +++++
 rtl/lyap_frame_engine.sv | 127 ++++++++++++
 tb/tb_lyap_frame_engine.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lyap_frame_engine_pkg.sv
// Shared definitions for the Lyapunov frame engine: colour-map mode encodings
// and the Q32.32 bit positions the colour byte is taken from.
package lyap_frame_engine_pkg;

    typedef enum logic [1:0] {
        MODE_GRAY = 2'b00,
        MODE_INV  = 2'b01,
        MODE_SIGN = 2'b10,
        MODE_RSVD = 2'b11
    } cmode_e;

    localparam int QFRAC = 32;
    // Colour byte: four integer bits over four fraction bits of the exponent.
    localparam int CM_LO = QFRAC - 4;
    localparam int CM_HI = QFRAC + 3;

endpackage

// File: rtl/lyap_frame_engine_colormap.sv
// Combinational lambda -> RGB mapping (gray, inverted gray, sign-split).
module lyap_colormap
    import lyap_frame_engine_pkg::*;
#(
    parameter int LW = 64
) (
    input  logic [LW-1:0] i_lambda,
    input  logic [1:0]    i_mode,
    output logic [7:0]    o_r,
    output logic [7:0]    o_g,
    output logic [7:0]    o_b
);

    logic [LW-1:0] w_abs;
    logic [7:0]    w_m;
    logic          w_most_neg;
    logic          w_unused;

    assign w_abs      = -i_lambda;
    assign w_m        = i_lambda[CM_HI:CM_LO];
    assign w_most_neg = (i_lambda == {1'b1, {(LW-1){1'b0}}});
    assign w_unused   = ^{w_abs[LW-1:CM_HI+1], w_abs[CM_LO-1:0]};

    always_comb begin
        o_r = 8'd0;
        o_g = 8'd0;
        o_b = 8'd0;
        case (cmode_e'(i_mode))
            MODE_INV: begin
                o_r = ~w_m;
                o_g = ~w_m;
                o_b = ~w_m;
            end
            MODE_SIGN: begin
                if (!i_lambda[LW-1])
                    o_r = w_m;
                else if (w_most_neg)
                    o_b = 8'hFF;   // |min| is not representable; saturate
                else
                    o_b = w_abs[CM_HI:CM_LO];
            end
            default: begin
                o_r = w_m;
                o_g = w_m;
                o_b = w_m;
            end
        endcase
    end

endmodule

// File: rtl/lyap_frame_engine.sv
// Raster-scan dispatcher for external lambda lanes with in-order retire,
// per-lane result slots and a single registered pixel output stage.
module lyap_frame_engine
    import lyap_frame_engine_pkg::*;
#(
    parameter int             XW     = 8,
    parameter int             YW     = 8,
    parameter int             NLANES = 4,
    parameter int             LW     = 64,
    parameter logic [LW-1:0]  P_STEP = LW'(64'h0000_0000_8000_0000),
    parameter logic [LW-1:0]  P_MAX  = LW'(64'h0000_0004_0000_0000)
) (
    input  logic                 CLK,
    input  logic                 NRST,
    input  logic                 EN,
    input  logic [1:0]           MODE,
    output logic [NLANES-1:0]    LANE_START,
    output logic [XW-1:0]        LANE_X,
    output logic [YW-1:0]        LANE_Y,
    output logic [LW-1:0]        LANE_P,
    input  logic [NLANES-1:0]    LANE_DONE,
    input  logic [NLANES*LW-1:0] LANE_LAMBDA,
    output logic                 OUT_VALID,
    input  logic                 OUT_READY,
    output logic [XW-1:0]        OX,
    output logic [YW-1:0]        OY,
    output logic [7:0]           R,
    output logic [7:0]           G,
    output logic [7:0]           B,
    output logic                 FRAME_END
);

    localparam int             PW    = (NLANES > 1) ? $clog2(NLANES) : 1;
    localparam logic [PW-1:0]  PLAST = PW'(NLANES - 1);

    logic [XW-1:0]              r_x;
    logic [YW-1:0]              r_y;
    logic [LW-1:0]              r_p;
    logic [PW-1:0]              r_dptr;
    logic [PW-1:0]              r_rptr;
    logic [NLANES-1:0]          r_busy;
    logic [NLANES-1:0]          r_svld;
    logic [NLANES-1:0][LW-1:0]  r_slam;
    logic [NLANES-1:0][XW-1:0]  r_sx;
    logic [NLANES-1:0][YW-1:0]  r_sy;

    logic       w_disp;
    logic       w_ret;
    logic       w_frame_last;
    logic [7:0] w_r;
    logic [7:0] w_g;
    logic [7:0] w_b;

    // A lane is reusable only once its previous result has left its slot.
    assign w_disp       = NRST & EN & ~r_busy[r_dptr] & ~r_svld[r_dptr];
    assign w_ret        = r_svld[r_rptr] & (~OUT_VALID | OUT_READY);
    assign w_frame_last = (&r_x) && (&r_y);

    assign LANE_START = w_disp ? (NLANES'(1) << r_dptr) : '0;
    assign LANE_X     = r_x;
    assign LANE_Y     = r_y;
    assign LANE_P     = r_p;

    lyap_colormap #(.LW(LW)) u_cmap (
        .i_lambda (r_slam[r_rptr]),
        .i_mode   (MODE),
        .o_r      (w_r),
        .o_g      (w_g),
        .o_b      (w_b)
    );

    always_ff @(posedge CLK) begin
        if (!NRST) begin
            r_x       <= '0;
            r_y       <= '0;
            r_p       <= '0;
            r_dptr    <= '0;
            r_rptr    <= '0;
            r_busy    <= '0;
            r_svld    <= '0;
            OUT_VALID <= 1'b0;
            FRAME_END <= 1'b0;
            OX        <= '0;
            OY        <= '0;
            R         <= '0;
            G         <= '0;
            B         <= '0;
        end else begin
            if (w_disp) begin
                r_sx[r_dptr] <= r_x;
                r_sy[r_dptr] <= r_y;
                r_dptr       <= (r_dptr == PLAST) ? '0 : r_dptr + 1'b1;
                r_x          <= r_x + 1'b1;
                if (&r_x)
                    r_y <= r_y + 1'b1;
                if (w_frame_last)
                    r_p <= (r_p >= P_MAX) ? '0 : r_p + P_STEP;
            end

            for (int i = 0; i < NLANES; i++) begin
                if (w_disp && r_dptr == PW'(i)) begin
                    r_busy[i] <= 1'b1;
                end else if (LANE_DONE[i] && r_busy[i]) begin
                    r_busy[i] <= 1'b0;
                    r_svld[i] <= 1'b1;
                    r_slam[i] <= LANE_LAMBDA[i*LW +: LW];
                end
                if (w_ret && r_rptr == PW'(i))
                    r_svld[i] <= 1'b0;
            end

            if (w_ret) begin
                OUT_VALID <= 1'b1;
                OX        <= r_sx[r_rptr];
                OY        <= r_sy[r_rptr];
                R         <= w_r;
                G         <= w_g;
                B         <= w_b;
                FRAME_END <= (&r_sx[r_rptr]) && (&r_sy[r_rptr]);
                r_rptr    <= (r_rptr == PLAST) ? '0 : r_rptr + 1'b1;
            end else if (OUT_READY) begin
                OUT_VALID <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lyap_frame_engine.sv
// Bench: behavioural lanes feed the engine; a scoreboard filled at dispatch
// is checked against retired pixels, plus a colour-map vector table.
module tb_lyap_frame_engine;

    localparam int          XW = 2;
    localparam int          YW = 2;
    localparam int          NL = 4;
    localparam int          LW = 64;
    localparam logic [63:0] PSTEP = 64'h0000_0000_8000_0000;
    localparam logic [63:0] PMAX  = 64'h0000_0004_0000_0000;
    localparam logic [63:0] MINNEG = 64'h8000_0000_0000_0000;

    logic                 CLK = 1'b0;
    logic                 NRST = 1'b0;
    logic                 EN = 1'b0;
    logic [1:0]           MODE = 2'd0;
    logic [NL-1:0]        LANE_START;
    logic [XW-1:0]        LANE_X;
    logic [YW-1:0]        LANE_Y;
    logic [LW-1:0]        LANE_P;
    logic [NL-1:0]        LANE_DONE = '0;
    logic [NL*LW-1:0]     LANE_LAMBDA = '0;
    logic                 OUT_VALID;
    logic                 OUT_READY = 1'b0;
    logic [XW-1:0]        OX;
    logic [YW-1:0]        OY;
    logic [7:0]           R, G, B;
    logic                 FRAME_END;

    always #5 CLK = ~CLK;

    lyap_frame_engine #(
        .XW(XW), .YW(YW), .NLANES(NL), .LW(LW), .P_STEP(PSTEP), .P_MAX(PMAX)
    ) dut (
        .CLK(CLK), .NRST(NRST), .EN(EN), .MODE(MODE),
        .LANE_START(LANE_START), .LANE_X(LANE_X), .LANE_Y(LANE_Y), .LANE_P(LANE_P),
        .LANE_DONE(LANE_DONE), .LANE_LAMBDA(LANE_LAMBDA),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .OX(OX), .OY(OY), .R(R), .G(G), .B(B), .FRAME_END(FRAME_END)
    );

    typedef struct {
        logic [1:0] x, y;
        logic [7:0] r, g, b;
        logic       fe;
    } exp_t;

    typedef struct {
        logic [1:0]  mode;
        logic [63:0] lam;
        logic [7:0]  r, g, b;
    } vec_t;

    int          n_tests = 0, n_fail = 0, n_out = 0, n_disp = 0;
    exp_t        sb[$];
    vec_t        tbl[9];
    logic [1:0]  ex = 0, ey = 0;
    logic [63:0] ep = 0;
    int          elane = 0;
    bit          saw_wrap = 0;
    int          lat_mode = 0, lam_mode = 0;
    logic [63:0] tbl_lam = 0;
    bit          lb[NL];
    int          lcnt[NL];
    logic [63:0] llam[NL];

    function automatic void chk(string nm, logic [63:0] got, logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endfunction

    function automatic void tmo(string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out waiting", nm);
    endfunction

    function automatic void cmap(input logic [1:0] md, input logic [63:0] lam,
                                 output logic [7:0] r, output logic [7:0] g, output logic [7:0] b);
        logic [63:0] a;
        logic [7:0]  m;
        m = 8'((lam >> 28) & 64'hFF);
        r = 0; g = 0; b = 0;
        if (md == 2'd1) begin
            r = 8'd255 - m; g = r; b = r;
        end else if (md == 2'd2) begin
            if (!lam[63]) r = m;
            else if (lam == MINNEG) b = 8'd255;
            else begin a = 64'd0 - lam; b = 8'((a >> 28) & 64'hFF); end
        end else begin
            r = m; g = m; b = m;
        end
    endfunction

    function automatic int lat_of(int li, int k);
        if (lat_mode == 0) return 10;
        if (lat_mode == 1) return (li == 0) ? 20 : 1 + (k*5 + li*3) % 13;
        return 1;
    endfunction

    // Behavioural lanes: deliver finished jobs, accept new starts and
    // predict the retired pixel for each dispatch.
    always @(negedge CLK) begin
        logic [NL-1:0] dn;
        logic [63:0]   lam;
        exp_t          e;
        int            li;
        dn = '0;
        for (int i = 0; i < NL; i++) begin
            if (lb[i]) begin
                if (lcnt[i] == 0) begin
                    dn[i] = 1'b1;
                    LANE_LAMBDA[i*LW +: LW] = llam[i];
                    lb[i] = 0;
                end else begin
                    lcnt[i]--;
                end
            end
        end
        LANE_DONE = dn;
        if (NRST && LANE_START != '0) begin
            chk("start_lane", 64'(LANE_START), 64'(1 << elane));
            chk("lane_xy", {60'd0, LANE_Y, LANE_X}, {60'd0, ey, ex});
            chk("lane_p", LANE_P, ep);
            li = elane;
            if (lam_mode == 0)      lam = 64'(ex) << 32;
            else if (lam_mode == 1) lam = tbl_lam;
            else                    lam = {$urandom, $urandom};
            llam[li] = lam;
            lb[li]   = 1;
            lcnt[li] = lat_of(li, n_disp);
            e.x = ex; e.y = ey; e.fe = (ex == 2'd3 && ey == 2'd3);
            cmap(MODE, lam, e.r, e.g, e.b);
            sb.push_back(e);
            n_disp++;
            if (ex == 2'd3) begin
                if (ey == 2'd3) begin
                    if (ep == PMAX) saw_wrap = 1;
                    ep = (ep >= PMAX) ? 64'd0 : ep + PSTEP;
                end
                ey++;
            end
            ex++;
            elane = (elane + 1) % NL;
        end
    end

    logic        pv = 0, pr = 0;
    logic [28:0] pvals = 0;

    always @(negedge CLK) begin
        exp_t e;
        if (NRST) begin
            if (pv && !pr) begin
                chk("hold_valid", 64'(OUT_VALID), 64'd1);
                chk("hold_data", 64'({OX, OY, R, G, B, FRAME_END}), 64'(pvals));
            end
            if (OUT_VALID && OUT_READY) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_out: got pixel (%0d,%0d) expected none", OX, OY);
                end else begin
                    e = sb.pop_front();
                    chk("out_xy", {60'd0, OY, OX}, {60'd0, e.y, e.x});
                    chk("out_rgb", 64'({R, G, B}), 64'({e.r, e.g, e.b}));
                    chk("frame_end", 64'(FRAME_END), 64'(e.fe));
                end
                n_out++;
            end
        end
        pv    = OUT_VALID & NRST;
        pr    = OUT_READY;
        pvals = {OX, OY, R, G, B, FRAME_END};
    end

    function automatic bit lanes_idle();
        for (int i = 0; i < NL; i++) if (lb[i]) return 0;
        return 1;
    endfunction

    task automatic wait_out(input int n);
        int target;
        target = n_out + n;
        for (int c = 0; c < 3000 && n_out < target; c++) @(posedge CLK);
        #1;
        if (n_out < target) tmo("wait_out");
    endtask

    task automatic drain();
        int c;
        EN = 0;
        c = 0;
        while (c < 600 && !(sb.size() == 0 && lanes_idle())) begin
            @(posedge CLK);
            c++;
        end
        #1;
        if (!(sb.size() == 0 && lanes_idle())) tmo("drain");
    endtask

    initial begin
        int  nb;
        bit  ok;
        tbl[0] = '{2'd0, 64'h0000_0003_0000_0000, 8'h30, 8'h30, 8'h30};
        tbl[1] = '{2'd1, 64'h0000_0003_0000_0000, 8'hCF, 8'hCF, 8'hCF};
        tbl[2] = '{2'd2, 64'hFFFF_FFFE_8000_0000, 8'h00, 8'h00, 8'h18};
        tbl[3] = '{2'd2, 64'h0000_0002_0000_0000, 8'h20, 8'h00, 8'h00};
        tbl[4] = '{2'd2, 64'h8000_0000_0000_0000, 8'h00, 8'h00, 8'hFF};
        tbl[5] = '{2'd3, 64'h0000_000A_5000_0000, 8'hA5, 8'hA5, 8'hA5};
        tbl[6] = '{2'd2, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 8'h00, 8'h00};
        tbl[7] = '{2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 8'hFF, 8'hFF};
        tbl[8] = '{2'd1, 64'h0000_0000_0000_0000, 8'hFF, 8'hFF, 8'hFF};
        for (int i = 0; i < NL; i++) begin lb[i] = 0; lcnt[i] = 0; llam[i] = 0; end

        // Reset state, with EN already high to show reset blocks dispatch.
        NRST = 0; EN = 1; OUT_READY = 1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_out_valid", 64'(OUT_VALID), 64'd0);
        chk("rst_lane_start", 64'(LANE_START), 64'd0);
        chk("rst_frame_end", 64'(FRAME_END), 64'd0);
        chk("rst_oxy", 64'({OX, OY}), 64'd0);
        chk("rst_rgb", 64'({R, G, B}), 64'd0);
        chk("rst_lane_p", LANE_P, 64'd0);
        @(posedge CLK); #1 NRST = 1;

        // Fixed latency echo of x<<32, gray map.
        MODE = 0; lam_mode = 0; lat_mode = 0;
        wait_out(64);
        drain();

        // Out-of-order lanes, random lambdas, sign-split map.
        MODE = 2; lam_mode = 2; lat_mode = 1; EN = 1;
        wait_out(64);
        drain();
        chk("no_loss", 64'(n_out), 64'(n_disp));

        // Back-pressure: slots and output stage fill, dispatch stops.
        MODE = 0; lam_mode = 0; lat_mode = 0;
        @(posedge CLK); #1 OUT_READY = 0; EN = 1;
        repeat (40) @(posedge CLK);
        @(negedge CLK);
        chk("stall_buffered", 64'(sb.size()), 64'(NL + 1));
        chk("stall_no_start", 64'(LANE_START), 64'd0);
        @(posedge CLK); #1 OUT_READY = 1;
        for (int k = 0; k < NL + 1; k++) begin
            @(negedge CLK);
            chk("b2b_valid", 64'(OUT_VALID), 64'd1);
        end
        wait_out(20);
        drain();

        // Continue sweeping until p has wrapped past P_MAX.
        lat_mode = 2; EN = 1;
        wait_out(64);
        drain();
        chk("p_wrap_seen", 64'(saw_wrap), 64'd1);

        // Colour-map vector table, one pixel per vector.
        lat_mode = 2; lam_mode = 1; OUT_READY = 0;
        for (int v = 0; v < 9; v++) begin
            MODE = tbl[v].mode; tbl_lam = tbl[v].lam; EN = 1;
            @(posedge CLK); #1 EN = 0;
            ok = 0;
            for (int c = 0; c < 50 && !ok; c++) begin
                @(negedge CLK);
                if (OUT_VALID) ok = 1;
            end
            if (!ok) tmo("tbl_wait");
            chk("tbl_rgb", 64'({R, G, B}), 64'({tbl[v].r, tbl[v].g, tbl[v].b}));
            @(posedge CLK); #1 OUT_READY = 1;
            @(posedge CLK); #1 OUT_READY = 0;
        end
        OUT_READY = 1;
        drain();

        // Reset with three lanes in flight; their late results must vanish.
        MODE = 0; lam_mode = 0; lat_mode = 0;
        @(posedge CLK); #1 EN = 1;
        repeat (3) @(posedge CLK);
        #1 EN = 0; NRST = 0;
        @(posedge CLK); #1 NRST = 1;
        sb.delete(); ex = 0; ey = 0; ep = 0; elane = 0;
        nb = 0;
        for (int i = 0; i < NL; i++) if (lb[i]) nb++;
        chk("rst_busy_lanes", 64'(nb), 64'd3);
        @(negedge CLK);
        chk("rst_mid_valid", 64'(OUT_VALID), 64'd0);
        for (int c = 0; c < 100 && !lanes_idle(); c++) @(posedge CLK);
        repeat (4) @(posedge CLK);
        @(negedge CLK);
        chk("late_done_no_out", 64'(OUT_VALID), 64'd0);
        @(posedge CLK); #1 EN = 1;
        wait_out(16);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
